// File: rtl/tb_memory.sv
// tb_memory: dual-port pipelined bench memory with byte-masked writes, preload port and tohost mailbox.
// Reads sample the array in the request cycle; responses emerge LATENCY cycles later, in order.
module tb_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst_data,
  output logic                    inst_err,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    data_err,
  input  logic                    ld_en,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   done_code
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BYTES);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  typedef logic [DATA_WIDTH-1:0] word_t;
  word_t mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-1:0] i_off, d_off, l_off;
  logic [IDXW-1:0] i_idx, d_idx, l_idx;
  logic i_bad, d_bad, l_bad, mb_wr, d_wr;
  word_t i_rd_d, d_rd_d;
  logic d_err_d;
  logic [LATENCY-1:0] iv_q, ie_q, dv_q, de_q;
  word_t id_q [LATENCY];
  word_t dd_q [LATENCY];
  logic done_q;
  word_t code_q;
  assign i_off = inst_addr - BASE_ADDR;
  assign d_off = data_addr - BASE_ADDR;
  assign l_off = ld_addr - BASE_ADDR;
  assign i_idx = i_off[OFF +: IDXW];
  assign d_idx = d_off[OFF +: IDXW];
  assign l_idx = l_off[OFF +: IDXW];
  // Bits above the index field catch both out-of-range and below-base (wrapped) addresses.
  assign i_bad = (|i_off[OFF-1:0]) | (|i_off[ADDR_WIDTH-1:OFF+IDXW]);
  assign d_bad = (|d_off[OFF-1:0]) | (|d_off[ADDR_WIDTH-1:OFF+IDXW]);
  assign l_bad = (|l_off[OFF-1:0]) | (|l_off[ADDR_WIDTH-1:OFF+IDXW]);
  assign mb_wr = data_req & data_we & (data_addr == TOHOST_ADDR);
  assign d_wr = data_req & data_we & ~d_bad & ~mb_wr;
  always_comb begin
    i_rd_d = i_bad ? '0 : mem[i_idx];
    d_rd_d = (d_bad | data_we) ? '0 : mem[d_idx];
    d_err_d = d_bad & ~mb_wr;
  end
  // Array write: preload is applied last so it wins over a same-word data write.
  always_ff @(posedge clk) begin
    if (d_wr)
      for (int b = 0; b < BYTES; b++)
        if (byte_enable[b]) mem[d_idx][8*b +: 8] <= wdata[8*b +: 8];
    if (ld_en && !l_bad) mem[l_idx] <= ld_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iv_q <= '0;
      ie_q <= '0;
      dv_q <= '0;
      de_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        id_q[k] <= '0;
        dd_q[k] <= '0;
      end
      done_q <= 1'b0;
      code_q <= '0;
    end else begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        iv_q[k] <= iv_q[k-1];
        ie_q[k] <= ie_q[k-1];
        dv_q[k] <= dv_q[k-1];
        de_q[k] <= de_q[k-1];
        id_q[k] <= id_q[k-1];
        dd_q[k] <= dd_q[k-1];
      end
      iv_q[0] <= inst_req;
      ie_q[0] <= i_bad;
      id_q[0] <= i_rd_d;
      dv_q[0] <= data_req;
      de_q[0] <= d_err_d;
      dd_q[0] <= d_rd_d;
      if (mb_wr) begin
        done_q <= 1'b1;
        code_q <= wdata;
      end
    end
  end
  assign inst_valid = iv_q[LATENCY-1];
  assign inst_err = inst_valid & ie_q[LATENCY-1];
  assign inst_data = inst_valid ? id_q[LATENCY-1] : '0;
  assign data_valid = dv_q[LATENCY-1];
  assign data_err = data_valid & de_q[LATENCY-1];
  assign rdata = data_valid ? dd_q[LATENCY-1] : '0;
  assign done = done_q;
  assign done_code = code_q;
endmodule

// File: tb/tb_tb_memory.sv
// tb_tb_memory: table vectors, directed corner sequences and random traffic against a
// word-array/response-queue reference model of tb_memory (LATENCY = 2).
module tb_tb_memory;
  localparam int LAT = 2;
  localparam int DEPTH = 1024;
  localparam logic [31:0] TOHOST = 32'h1000_0000;
  logic clk = 1'b0;
  logic rst;
  logic inst_req, inst_valid, inst_err;
  logic [31:0] inst_addr, inst_data;
  logic data_req, data_we, data_valid, data_err;
  logic [31:0] data_addr, wdata, rdata;
  logic [3:0] byte_enable;
  logic ld_en, done;
  logic [31:0] ld_addr, ld_data, done_code;

  tb_memory #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_err(inst_err),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .byte_enable(byte_enable), .wdata(wdata), .data_valid(data_valid),
    .rdata(rdata), .data_err(data_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .done(done), .done_code(done_code)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic err; logic [31:0] d;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic err; logic [31:0] rd;} vec_t;
  rsp_t iq[$], dq[$];
  logic [31:0] mm [DEPTH];
  logic mdone;
  logic [31:0] mcode;
  int cyc, n_vec, n_err;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic bad(logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] rd(logic [31:0] a);
    return bad(a) ? 32'h0 : mm[int'(a / 4)];
  endfunction

  // One clock cycle: compare outputs with the model, then apply this cycle's inputs to the model.
  task automatic cycle();
    rsp_t r;
    logic [31:0] w;
    #1;
    if (!rst) begin
      iq.delete();
      dq.delete();
      mdone = 1'b0;
      mcode = '0;
    end
    if (iq.size() > 0 && iq[0].due == cyc) begin
      r = iq.pop_front();
      check("inst_rsp", {inst_valid, inst_err, inst_data}, {1'b1, r.err, r.d});
    end else check("inst_idle", {inst_valid, inst_err, inst_data}, 64'h0);
    if (dq.size() > 0 && dq[0].due == cyc) begin
      r = dq.pop_front();
      check("data_rsp", {data_valid, data_err, rdata}, {1'b1, r.err, r.d});
    end else check("data_idle", {data_valid, data_err, rdata}, 64'h0);
    check("done", done, mdone);
    check("done_code", done_code, mcode);
    if (rst) begin
      if (inst_req) iq.push_back('{cyc + LAT, bad(inst_addr), rd(inst_addr)});
      if (data_req && data_we && data_addr == TOHOST) begin
        dq.push_back('{cyc + LAT, 1'b0, 32'h0});
        mdone = 1'b1;
        mcode = wdata;
      end else if (data_req && data_we) begin
        dq.push_back('{cyc + LAT, bad(data_addr), 32'h0});
        if (!bad(data_addr)) begin
          w = mm[int'(data_addr / 4)];
          for (int b = 0; b < 4; b++) if (byte_enable[b]) w[8*b +: 8] = wdata[8*b +: 8];
          mm[int'(data_addr / 4)] = w;
        end
      end else if (data_req) dq.push_back('{cyc + LAT, bad(data_addr), rd(data_addr)});
    end
    if (ld_en && !bad(ld_addr)) mm[int'(ld_addr / 4)] = ld_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    inst_req = 0;
    data_req = 0;
    data_we = 0;
    ld_en = 0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1;
    ld_addr = a;
    ld_data = d;
    cycle();
    ld_en = 0;
  endtask

  function automatic logic [31:0] raddr();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
    if (s == 1) return 32'h1000 + $urandom_range(0, 255) * 4;
    if (s == 2) return TOHOST;
    return $urandom_range(0, 63) * 4;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 32'h10,   4'b0101, 32'h1122_3344, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,   4'b0000, 32'h0,         1'b0, 32'hAA22_CC44};
    tbl[2]  = '{1'b0, 32'h2,    4'b0000, 32'h0,         1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h1000, 4'b0000, 32'h0,         1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h1000, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,    4'b0000, 32'h0,         1'b0, 32'h0000_0013};
    tbl[6]  = '{1'b0, 32'hFFC,  4'b0000, 32'h0,         1'b0, 32'h1234_5678};
    tbl[7]  = '{1'b1, 32'h14,   4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h14,   4'b0000, 32'h0,         1'b0, 32'h5566_7788};
    tbl[9]  = '{1'b1, 32'h18,   4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h1A,   4'b1111, 32'h0BAD_0BAD, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h18,   4'b0000, 32'h0,         1'b0, 32'hCAFE_F00D};
    cyc = 0;
    n_vec = 0;
    n_err = 0;
    mdone = 0;
    mcode = 0;
    idle();
    inst_addr = 0;
    data_addr = 0;
    byte_enable = 0;
    wdata = 0;
    ld_addr = 0;
    ld_data = 0;
    rst = 1;
    #1 rst = 0;
    repeat (3) cycle();
    for (int i = 0; i < DEPTH; i++) ld(i * 4, $urandom);
    rst = 1;
    ld(32'h0, 32'h0000_0013);
    ld(32'h10, 32'hAABB_CCDD);
    ld(32'h14, 32'h5566_7788);
    ld(32'hFFC, 32'h1234_5678);
    ld(32'h20, 32'h0000_0001);
    for (int i = 0; i < 12; i++) begin
      data_req = 1;
      data_we = tbl[i].we;
      data_addr = tbl[i].addr;
      byte_enable = tbl[i].be;
      wdata = tbl[i].wd;
      cycle();
      idle();
      repeat (LAT - 1) cycle();
      check($sformatf("tbl%0d", i), {data_valid, data_err, rdata}, {1'b1, tbl[i].err, tbl[i].rd});
    end
    cycle();
    inst_req = 1;
    inst_addr = 32'h0;
    cycle();
    idle();
    check("lat_n1", inst_valid, 1'b0);
    cycle();
    check("lat_n2", {inst_valid, inst_data}, {1'b1, 32'h0000_0013});
    cycle();
    check("lat_n3", inst_valid, 1'b0);
    inst_req = 1;
    inst_addr = 32'h20;
    data_req = 1;
    data_we = 1;
    data_addr = 32'h20;
    byte_enable = 4'hF;
    wdata = 32'h2;
    cycle();
    idle();
    cycle();
    check("rbw_old", {inst_valid, inst_data}, {1'b1, 32'h1});
    data_req = 1;
    data_addr = 32'h20;
    cycle();
    idle();
    cycle();
    check("rbw_new", {data_valid, rdata}, {1'b1, 32'h2});
    data_req = 1;
    data_we = 1;
    data_addr = TOHOST;
    wdata = 32'h1;
    cycle();
    idle();
    check("tohost_set", {done, done_code}, {1'b1, 32'h1});
    repeat (3) cycle();
    check("tohost_hold", {done, done_code}, {1'b1, 32'h1});
    rst = 0;
    cycle();
    check("tohost_rst", {done, done_code}, 64'h0);
    rst = 1;
    cycle();
    inst_req = 1;
    inst_addr = 32'h0;
    cycle();
    inst_addr = 32'h4;
    cycle();
    inst_addr = 32'h8;
    rst = 0;
    cycle();
    idle();
    repeat (2) cycle();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("flush_none", inst_valid, 1'b0);
    end
    inst_req = 1;
    inst_addr = 32'h0;
    cycle();
    inst_addr = 32'h4;
    cycle();
    inst_addr = 32'h8;
    check("flush_keep", {inst_valid, inst_data}, {1'b1, 32'h0000_0013});
    cycle();
    idle();
    repeat (LAT + 1) cycle();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      inst_req = $urandom_range(0, 1);
      inst_addr = raddr();
      data_req = rst && ($urandom_range(0, 1) != 0);
      data_we = $urandom_range(0, 1);
      data_addr = raddr();
      byte_enable = $urandom_range(0, 15);
      wdata = $urandom;
      ld_en = ($urandom_range(0, 15) == 0);
      ld_addr = raddr();
      ld_data = $urandom;
      cycle();
    end
    rst = 1;
    idle();
    repeat (LAT + 2) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
